led_chase_scheduler: RTL and testbench

//  Drives all board LEDs from one shared PWM counter, which sets per-channel brightness ("chase with fading tail").
//  A step scheduler moves a full-brightness head across NUM_CH LEDs. Every other channel's duty halves each step.

---
 rtl/led_pwm_pkg.sv | 19 +
 rtl/pwm_channel.sv | 37 +++
 rtl/led_chase_scheduler.sv | 113 +++++++++++
 tb/tb_led_chase_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - shared constants, FSM state type and duty helper for the LED chase
package led_pwm_pkg;

    localparam int LED_NUM_CH   = 26;
    localparam int LED_PWM_BITS = 8;
    localparam int LED_PRE_BITS = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN_FWD,
        RUN_REV
    } chase_state_t;

    // Full-brightness duty for a counter of the given width.
    function automatic int duty_max(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one LED channel: duty register with halving decay and registered compare
module pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int PWM_BITS = LED_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                load_max,
    input  logic                decay,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pwm
);

    localparam logic [PWM_BITS-1:0] DUTY_FULL = PWM_BITS'(duty_max(PWM_BITS));

    logic [PWM_BITS-1:0] duty;

    // The head load wins over the decay so a step can shift everyone and re-light one channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty <= '0;
            pwm  <= 1'b0;
        end else begin
            pwm <= (pwm_cnt < duty);
            if (clear) begin
                duty <= '0;
            end else if (load_max) begin
                duty <= DUTY_FULL;
            end else if (decay) begin
                duty <= duty >> 1;
            end
        end
    end

endmodule

// File: rtl/led_chase_scheduler.sv
// rtl/led_chase_scheduler.sv - shared PWM counter, step prescaler and chase FSM driving all LEDs
module led_chase_scheduler
    import led_pwm_pkg::*;
#(
    parameter int NUM_CH   = LED_NUM_CH,
    parameter int PWM_BITS = LED_PWM_BITS,
    parameter int PRE_BITS = LED_PRE_BITS
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                enable,
    input  logic                mode,
    input  logic [PRE_BITS-1:0] speed,
    output logic [NUM_CH-1:0]   pwm_out,
    output logic [4:0]          pos,
    output logic                dir,
    output logic                frame_tick
);

    localparam logic [PWM_BITS-1:0] CNT_MAX  = PWM_BITS'(duty_max(PWM_BITS));
    localparam logic [4:0]          LAST_POS = 5'(NUM_CH - 1);

    chase_state_t        state;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PRE_BITS-1:0] pre_cnt;
    logic                frame_end;
    logic                running;
    logic                step;
    logic [4:0]          next_pos;
    logic                next_rev;
    logic                clear;
    logic                decay;
    logic [NUM_CH-1:0]   load_max;

    assign frame_end = (pwm_cnt == CNT_MAX);
    assign running   = (state != IDLE);
    assign step      = frame_end && (pre_cnt == speed) && running;

    // Head position after a move; mode=1 in reverse turns around without stalling.
    always_comb begin
        next_pos = pos;
        next_rev = 1'b0;
        if (state == RUN_REV) begin
            if (mode || pos == 5'd0) begin
                next_pos = (pos == LAST_POS) ? 5'd0 : pos + 5'd1;
            end else begin
                next_pos = pos - 5'd1;
                next_rev = 1'b1;
            end
        end else begin
            if (pos != LAST_POS) begin
                next_pos = pos + 5'd1;
            end else if (!mode) begin
                next_pos = pos - 5'd1;
                next_rev = 1'b1;
            end else begin
                next_pos = 5'd0;
            end
        end
    end

    assign clear = !enable;
    assign decay = enable && step;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pwm_cnt    <= '0;
            pre_cnt    <= '0;
            pos        <= 5'd0;
            dir        <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            pwm_cnt    <= pwm_cnt + 1'b1;
            frame_tick <= frame_end;
            if (!enable) begin
                state   <= IDLE;
                pos     <= 5'd0;
                dir     <= 1'b0;
                pre_cnt <= '0;
            end else if (state == IDLE) begin
                state <= RUN_FWD;
            end else begin
                if (frame_end) begin
                    pre_cnt <= step ? '0 : pre_cnt + 1'b1;
                end
                if (step) begin
                    pos   <= next_pos;
                    dir   <= next_rev;
                    state <= next_rev ? RUN_REV : RUN_FWD;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load_max[i] = enable &&
                             ((state == IDLE && i == 0) || (step && next_pos == 5'(i)));

        pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk      (CLOCK_50),
            .rst      (reset),
            .clear    (clear),
            .load_max (load_max[i]),
            .decay    (decay),
            .pwm_cnt  (pwm_cnt),
            .pwm      (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_led_chase_scheduler.sv
// tb/tb_led_chase_scheduler.sv - randomized directed bench with a frame-level chase model
module tb_led_chase_scheduler;

    localparam int NCH   = 26;
    localparam int FRAME = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        mode;
    logic [3:0]  speed;
    logic [25:0] pwm_out;
    logic [4:0]  pos;
    logic        dir;
    logic        frame_tick;

    led_chase_scheduler dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .enable     (enable),
        .mode       (mode),
        .speed      (speed),
        .pwm_out    (pwm_out),
        .pos        (pos),
        .dir        (dir),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int m_duty[NCH];
    int m_pos;
    int m_dir;
    int m_pre;
    bit m_run;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_idle();
        m_run = 1'b0;
        for (int i = 0; i < NCH; i++) m_duty[i] = 0;
        m_pos = 0;
        m_dir = 0;
        m_pre = 0;
    endtask

    task automatic model_enable();
        model_idle();
        m_run     = 1'b1;
        m_duty[0] = 255;
    endtask

    // One chase step: tail fades by half, head moves by the bounce/wrap rules and lights fully.
    task automatic model_step();
        for (int i = 0; i < NCH; i++) m_duty[i] = m_duty[i] / 2;
        if (m_dir == 0) begin
            if (m_pos < NCH - 1) m_pos = m_pos + 1;
            else if (mode == 1'b0) begin m_pos = NCH - 2; m_dir = 1; end
            else m_pos = 0;
        end else begin
            if (mode == 1'b1 || m_pos == 0) begin m_pos = (m_pos + 1) % NCH; m_dir = 0; end
            else m_pos = m_pos - 1;
        end
        m_duty[m_pos] = 255;
    endtask

    task automatic model_frame_end();
        if (m_run) begin
            if (m_pre == int'(speed)) begin
                m_pre = 0;
                model_step();
            end else begin
                m_pre = (m_pre + 1) % 16;
            end
        end
    endtask

    function automatic logic [25:0] exp_vec(input int k);
        logic [25:0] v;
        for (int i = 0; i < NCH; i++) v[i] = (k >= 1) && (k - 1 < m_duty[i]);
        return v;
    endfunction

    task automatic sync_frame();
        for (int n = 0; n < 300 && frame_tick !== 1'b1; n++) @(negedge clk);
        chk("sync.frame_tick", 64'(frame_tick), 64'd1);
    endtask

    // Called at the sample where frame_tick is high; checks every cycle of one frame.
    task automatic run_frame(input string tag);
        for (int k = 0; k < FRAME; k++) begin
            if (k == 0) begin
                chk({tag, ".tick"}, 64'(frame_tick), 64'd1);
                chk({tag, ".pos"}, 64'(pos), 64'(m_pos));
                chk({tag, ".dir"}, 64'(dir), 64'(m_dir));
            end
            if (k == FRAME / 2) chk({tag, ".tick_low"}, 64'(frame_tick), 64'd0);
            chk({tag, ".pwm"}, 64'(pwm_out), 64'(exp_vec(k)));
            @(negedge clk);
        end
        model_frame_end();
    endtask

    task automatic start_run(input logic [3:0] spd, input logic md);
        sync_frame();
        speed  = spd;
        mode   = md;
        enable = 1'b1;
        model_enable();
        repeat (FRAME) @(negedge clk);
        model_frame_end();
    endtask

    initial begin
        int guard;
        int old_pos;

        rst    = 1'b1;
        enable = 1'b0;
        mode   = 1'b0;
        speed  = 4'd0;
        model_idle();
        repeat (3) @(negedge clk);
        chk("reset.pwm", 64'(pwm_out), 64'd0);
        chk("reset.pos", 64'(pos), 64'd0);
        chk("reset.dir", 64'(dir), 64'd0);
        chk("reset.tick", 64'(frame_tick), 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle.pwm", 64'(pwm_out), 64'd0);
        chk("idle.pos", 64'(pos), 64'd0);

        start_run(4'd1, 1'b0);
        run_frame("head0");
        run_frame("step1");
        speed = 4'd0;

        for (int f = 0; f < 52; f++) run_frame("bounce");

        mode = 1'b1;
        for (int f = 0; f < 30; f++) run_frame("wrap");

        mode = 1'b0;
        guard = 0;
        while (m_dir == 0 && guard < 40) begin run_frame("to_rev"); guard++; end
        chk("to_rev.reached", 64'(m_dir), 64'd1);
        run_frame("rev");
        old_pos = m_pos;
        mode = 1'b1;
        run_frame("rev_to_wrap");
        chk("rev_to_wrap.pos", 64'(pos), 64'((old_pos + 1) % NCH));
        chk("rev_to_wrap.dir", 64'(dir), 64'd0);

        mode  = 1'b0;
        speed = 4'd3;
        for (int f = 0; f < 12; f++) run_frame("speed3");

        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 2) == 0) mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 6) == 0) speed = 4'($urandom_range(4, 15));
            else speed = 4'($urandom_range(0, 2));
            run_frame("rand");
        end

        speed = 4'd0;
        mode  = 1'b0;
        repeat ($urandom_range(10, 200)) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("drop.pos", 64'(pos), 64'd0);
        chk("drop.dir", 64'(dir), 64'd0);
        @(negedge clk);
        chk("drop.pwm", 64'(pwm_out), 64'd0);
        model_idle();
        sync_frame();
        run_frame("dark");
        start_run(4'd0, 1'b0);
        for (int f = 0; f < 4; f++) run_frame("reenable");

        repeat ($urandom_range(10, 200)) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.pwm", 64'(pwm_out), 64'd0);
        chk("arst.pos", 64'(pos), 64'd0);
        chk("arst.dir", 64'(dir), 64'd0);
        chk("arst.tick", 64'(frame_tick), 64'd0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_idle();
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("post_rst.pwm", 64'(pwm_out), 64'd0);
        end
        chk("post_rst.pos", 64'(pos), 64'd0);
        start_run(4'd2, 1'b1);
        for (int f = 0; f < 6; f++) run_frame("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
